pipe_stage_skid: RTL

//  Parametrised elastic pipeline register for inter-stage boundaries (EX/MEM and others).

---
 rtl/pipe_stage_skid.sv | 104 ++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a 2-entry skid buffer, flush, bubble output,
// occupancy report and a saturating back-pressure cycle counter.
module pipe_stage_skid #(
  parameter int unsigned          DATA_W     = 64,
  parameter logic [DATA_W-1:0]    RESET_DATA = '0,
  parameter int unsigned          CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              in_fire, out_fire;

  assign out_valid = (state_q == S_ONE) || (state_q == S_TWO);
  assign out_data  = out_valid ? main_q : RESET_DATA;
  assign in_ready  = in_ready_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = S_TWO;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // Flush wins over any transfer decided above; the downstream beat is still consumed.
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = RESET_DATA;
      skid_d  = RESET_DATA;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_EMPTY;
      main_q      <= RESET_DATA;
      skid_q      <= RESET_DATA;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != S_TWO);
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
